// File: rtl/pico.sv
// Shared definitions for the pico core and its program loader.
package pico;

  localparam int unsigned A      = 8;
  localparam int unsigned W_INST = 16;
  localparam int unsigned W_LCNT = 16;

  typedef enum logic [2:0] {
    RUN,
    HDR_HI,
    HDR_LO,
    DATA,
    ERR
  } ldrState;

  function automatic int unsigned bytes_per_word(input int unsigned w_inst);
    return (w_inst + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-fetch bus between the loader, its feeder and the core.
interface prog_loader_if #(
  parameter int unsigned A      = pico::A,
  parameter int unsigned W_INST = pico::W_INST
);

  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [A-1:0]      prog_addr_i;
  logic [W_INST-1:0] prog_data_o;

  modport master (
    output rx_data_i, rx_valid_i, prog_addr_i,
    input  rx_ready_o, prog_data_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, prog_addr_i,
    output rx_ready_o, prog_data_o
  );

endinterface

// File: rtl/prog_ram.sv
// Program memory: synchronous write, asynchronous read; kept separate so it can be swapped.
module prog_ram #(
  parameter int unsigned A = 8,
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [A-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem [0:(1 << A) - 1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed byte image into program memory, holding the core in reset meanwhile.
module prog_loader #(
  parameter int unsigned A      = pico::A,
  parameter int unsigned W_INST = pico::W_INST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_req_i,
  prog_loader_if.slave     bus,
  output logic             core_n_rst_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [A:0]       words_o
);

  import pico::*;

  localparam int unsigned BPW  = bytes_per_word(W_INST);
  localparam int unsigned BI_W = $clog2(BPW + 1);
  localparam int unsigned AW   = A + 1;

  ldrState           state;
  logic [W_LCNT-1:0] len_q;
  logic [AW-1:0]     waddr_q;
  logic [BI_W-1:0]   bidx_q;
  logic [W_INST-1:0] asm_q;

  logic              xfer;
  logic              we;
  logic              last_byte;
  logic              last_word;
  logic              hdr_oversize;
  logic [W_LCNT-1:0] hdr_len;
  logic [W_INST-1:0] asm_next;

  // A load request wins over any byte offered in the same cycle.
  assign bus.rx_ready_o = ((state == HDR_HI) || (state == HDR_LO) || (state == DATA))
                          && !load_req_i;
  assign xfer           = bus.rx_valid_i && bus.rx_ready_o;

  // Truncation drops the unused top bits of the first byte when W_INST is not byte-aligned.
  assign asm_next     = W_INST'({asm_q, bus.rx_data_i});
  assign hdr_len      = {len_q[W_LCNT-1:8], bus.rx_data_i};
  assign hdr_oversize = 32'(hdr_len) > (32'd1 << A);
  assign last_byte    = (bidx_q == BI_W'(BPW - 1));
  assign last_word    = ((waddr_q + AW'(1)) == AW'(len_q));
  assign we           = xfer && (state == DATA) && last_byte;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= RUN;
      core_n_rst_o <= 1'b1;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
      words_o      <= '0;
      len_q        <= '0;
      waddr_q      <= '0;
      bidx_q       <= '0;
      asm_q        <= '0;
    end else if (load_req_i) begin
      state        <= HDR_HI;
      core_n_rst_o <= 1'b0;
      busy_o       <= 1'b1;
      err_o        <= 1'b0;
      words_o      <= '0;
      len_q        <= '0;
      waddr_q      <= '0;
      bidx_q       <= '0;
      asm_q        <= '0;
    end else begin
      case (state)
        RUN: begin
          core_n_rst_o <= 1'b1;
          busy_o       <= 1'b0;
        end
        HDR_HI: begin
          if (xfer) begin
            len_q[W_LCNT-1:8] <= bus.rx_data_i;
            state             <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            len_q <= hdr_len;
            if (hdr_len == '0) begin
              state        <= RUN;
              core_n_rst_o <= 1'b1;
              busy_o       <= 1'b0;
            end else if (hdr_oversize) begin
              state  <= ERR;
              err_o  <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            if (last_byte) begin
              bidx_q  <= '0;
              asm_q   <= '0;
              waddr_q <= waddr_q + AW'(1);
              if (last_word) begin
                state        <= RUN;
                words_o      <= AW'(len_q);
                core_n_rst_o <= 1'b1;
                busy_o       <= 1'b0;
              end
            end else begin
              bidx_q <= bidx_q + BI_W'(1);
              asm_q  <= asm_next;
            end
          end
        end
        ERR: begin
          err_o        <= 1'b1;
          core_n_rst_o <= 1'b0;
          busy_o       <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  prog_ram #(
    .A (A),
    .W (W_INST)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr_q[A-1:0]),
    .wdata_i (asm_next),
    .raddr_i (bus.prog_addr_i),
    .rdata_o (bus.prog_data_o)
  );

endmodule
